// File: rtl/tone_decoder.sv
// Half-period tone decoder: measures a square-wave input in clk cycles and reports
// the stable note code from the seven-entry table, falling to silence after a timeout.
module tone_decoder #(
  parameter int TOL         = 256,
  parameter int MATCH_CNT   = 4,
  parameter int SIL_TIMEOUT = 131072,
  // Entry i holds the half-period for note code i+1 (G3 .. A4).
  parameter logic [6:0][17:0] HALF_PERIOD = {18'd28609, 18'd32112, 18'd38188, 18'd42862,
                                             18'd48113, 18'd57217, 18'd64223}
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tone_in,
  output logic [2:0]  note,
  output logic        note_valid,
  output logic [17:0] period,
  output logic        active
);

  localparam int               CNT_W      = 18;
  localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(SIL_TIMEOUT);
  localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(SIL_TIMEOUT - 1);
  localparam logic [3:0]       MATCH      = 4'(MATCH_CNT);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Class 0 doubles as "unknown": silence is never a classification result.
  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    logic signed [31:0] diff;
    logic [2:0]         c;
    c = 3'd0;
    for (int i = 0; i < 7; i++) begin
      diff = $signed({14'd0, p}) - $signed({14'd0, HALF_PERIOD[i]});
      if (diff <= TOL && diff >= -TOL) c = 3'(i + 1);
    end
    return c;
  endfunction

  logic             sync_p0, sync_p1, sync_p2;
  logic             tone_edge;
  logic [CNT_W-1:0] cnt;
  logic             measuring;
  logic             vld_p1;
  logic             timeout_hit;
  logic [2:0]       class_p2;
  logic             vld_p2;
  logic [3:0]       stab, stab_nxt;
  logic [2:0]       last_cls, last_nxt;
  logic [2:0]       note_nxt;
  logic             pulse_nxt;

  // Stage: synchronizer and edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= tone_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign tone_edge   = sync_p1 ^ sync_p2;
  // The edge wins over a timeout landing on the same cycle.
  assign timeout_hit = !tone_edge && (cnt == TIMEOUT_M1);

  // Stage: half-period measurement
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      measuring <= 1'b0;
      period    <= '0;
      vld_p1    <= 1'b0;
      active    <= 1'b0;
    end else begin
      vld_p1 <= tone_edge && measuring;
      if (tone_edge) begin
        if (measuring) period <= sat_inc(cnt);
        cnt       <= '0;
        measuring <= 1'b1;
        active    <= 1'b1;
      end else begin
        if (timeout_hit) begin
          measuring <= 1'b0;
          active    <= 1'b0;
        end
        // Once timed out, the counter parks at the timeout value until the next edge.
        if (!(cnt == TIMEOUT_V && !measuring)) cnt <= sat_inc(cnt);
      end
    end
  end

  // Stage: classification against the note table
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      class_p2 <= 3'd0;
      vld_p2   <= 1'b0;
    end else begin
      class_p2 <= classify(period);
      vld_p2   <= vld_p1;
    end
  end

  // Stage: stability counting and note commit
  always_comb begin
    stab_nxt  = stab;
    last_nxt  = last_cls;
    note_nxt  = note;
    pulse_nxt = 1'b0;
    if (timeout_hit) begin
      stab_nxt = 4'd0;
      last_nxt = 3'd0;
      if (note != 3'd0) begin
        note_nxt  = 3'd0;
        pulse_nxt = 1'b1;
      end
    end else if (vld_p2) begin
      if (class_p2 == 3'd0) begin
        stab_nxt = 4'd0;
        last_nxt = 3'd0;
      end else if (class_p2 == last_cls) begin
        if (stab < MATCH) stab_nxt = stab + 4'd1;
      end else begin
        last_nxt = class_p2;
        stab_nxt = 4'd1;
      end
      if (class_p2 != 3'd0 && stab_nxt == MATCH && class_p2 != note) begin
        note_nxt  = class_p2;
        pulse_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stab       <= 4'd0;
      last_cls   <= 3'd0;
      note       <= 3'd0;
      note_valid <= 1'b0;
    end else begin
      stab       <= stab_nxt;
      last_cls   <= last_nxt;
      note       <= note_nxt;
      note_valid <= pulse_nxt;
    end
  end

endmodule
